grb_shipper: RTL and testbench

- WS2812-style serial LED transmitter; the far end of the ship/done handshake driven by the ship-control state machine.
- On a ship request it fetches NUM_LEDS 24-bit GRB words from an external pixel store and serialises them MSB-first as pulse-width-coded bits.
- It then holds the line low for the latch/reset time and pulses done for one cycle.

---
 rtl/ws2812_pkg.sv | 18 +
 rtl/ws_bit_encoder.sv | 43 ++++
 rtl/grb_shipper.sv | 104 ++++++++++
 tb/tb_grb_shipper.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/ws2812_pkg.sv
// Shared types and timing defaults for the WS2812 serial transmitter.
// GRB_SHIPPER_RGBW_EN widens each pixel word from 24-bit GRB to 32-bit GRBW.
package ws2812_pkg;
  localparam int DEF_T0H    = 40;
  localparam int DEF_T1H    = 80;
  localparam int DEF_TBIT   = 125;
  localparam int DEF_TRESET = 5000;

`ifdef GRB_SHIPPER_RGBW_EN
  localparam int BITS_PER_PIXEL = 32;
`else
  localparam int BITS_PER_PIXEL = 24;
`endif

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_BIT_HI, ST_BIT_LO, ST_LATCH, ST_DONE
  } state_t;
endpackage

// File: rtl/ws_bit_encoder.sv
// Pulse-width encoder for one WS2812 bit: high for T1H/T0H cycles, low for the rest of TBIT.
// A start restarts the bit timer; o_hi_last/o_bit_done flag the final high and final bit cycles.
module ws_bit_encoder #(
  parameter int T0H  = 40,
  parameter int T1H  = 80,
  parameter int TBIT = 125
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_start,
  input  logic i_bit,
  output logic o_line,
  output logic o_hi_last,
  output logic o_bit_done
);
  localparam int CW = (TBIT > 2) ? $clog2(TBIT) : 1;
  // r_cnt runs TBIT-1 down to 0; the last high cycle is where r_cnt == TBIT-TH
  localparam logic [CW-1:0] LAST_HI0 = CW'(TBIT - T0H);
  localparam logic [CW-1:0] LAST_HI1 = CW'(TBIT - T1H);

  logic [CW-1:0] r_cnt;
  logic          r_line;
  logic          r_bit;

  assign o_line     = r_line;
  assign o_hi_last  = r_line && (r_cnt == (r_bit ? LAST_HI1 : LAST_HI0));
  assign o_bit_done = (r_cnt == '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt  <= '0;
      r_line <= 1'b0;
      r_bit  <= 1'b0;
    end else if (i_start) begin
      r_cnt  <= CW'(TBIT - 1);
      r_line <= 1'b1;
      r_bit  <= i_bit;
    end else begin
      if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
      if (o_hi_last)   r_line <= 1'b0;
    end
  end
endmodule

// File: rtl/grb_shipper.sv
// WS2812 frame transmitter: fetches NUM_LEDS pixel words, serialises them MSB-first, latches, pulses done.
// GRB_SHIPPER_RGBW_EN (via ws2812_pkg) selects 32-bit GRBW pixels instead of 24-bit GRB.
module grb_shipper import ws2812_pkg::*; #(
  parameter int NUM_LEDS = 8,
  parameter int T0H      = DEF_T0H,
  parameter int T1H      = DEF_T1H,
  parameter int TBIT     = DEF_TBIT,
  parameter int TRESET   = DEF_TRESET,
  parameter int ADDR_W   = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_ship,
  input  logic [BITS_PER_PIXEL-1:0] i_grb_data,
  output logic [ADDR_W-1:0]         o_led_addr,
  output logic                      o_dout,
  output logic                      o_done,
  output logic                      o_busy
);
  localparam int BPP = BITS_PER_PIXEL;
  localparam int BCW = $clog2(BPP);
  localparam int TRW = (TRESET > 1) ? $clog2(TRESET) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_LEDS - 1);

  state_t            r_state;
  logic [BPP-1:0]    r_shreg;
  logic [BCW-1:0]    r_bitcnt;
  logic [TRW-1:0]    r_timer;
  logic [ADDR_W-1:0] r_addr;
  logic              r_done;
  logic              r_busy;

  logic w_start, w_bit_val, w_hi_last, w_bit_done;

  // Next bit launches on the same edge the FSM leaves FETCH or finishes a non-final bit
  assign w_start   = (r_state == ST_FETCH) ||
                     (r_state == ST_BIT_LO && w_bit_done && r_bitcnt != '0);
  assign w_bit_val = (r_state == ST_FETCH) ? i_grb_data[BPP-1] : r_shreg[BPP-2];

  ws_bit_encoder #(.T0H(T0H), .T1H(T1H), .TBIT(TBIT)) u_enc (
    .i_clk      (i_clk),
    .i_rst_n    (i_reset),
    .i_start    (w_start),
    .i_bit      (w_bit_val),
    .o_line     (o_dout),
    .o_hi_last  (w_hi_last),
    .o_bit_done (w_bit_done)
  );

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state  <= ST_IDLE;
      r_shreg  <= '0;
      r_bitcnt <= '0;
      r_timer  <= '0;
      r_addr   <= '0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (i_ship) begin
          r_state <= ST_FETCH;
          r_addr  <= '0;
          r_busy  <= 1'b1;
        end
        ST_FETCH: begin
          r_shreg  <= i_grb_data;
          r_bitcnt <= BCW'(BPP - 1);
          r_state  <= ST_BIT_HI;
        end
        ST_BIT_HI: if (w_hi_last) r_state <= ST_BIT_LO;
        ST_BIT_LO: if (w_bit_done) begin
          r_shreg <= {r_shreg[BPP-2:0], 1'b0};
          if (r_bitcnt != '0) begin
            r_bitcnt <= r_bitcnt - BCW'(1);
            r_state  <= ST_BIT_HI;
          end else if (r_addr == LAST_ADDR) begin
            r_timer <= TRW'(TRESET - 1);
            r_state <= ST_LATCH;
          end else begin
            r_addr  <= r_addr + ADDR_W'(1);
            r_state <= ST_FETCH;
          end
        end
        ST_LATCH: if (r_timer == '0) begin
          r_done  <= 1'b1;
          r_state <= ST_DONE;
        end else begin
          r_timer <= r_timer - TRW'(1);
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_led_addr = r_addr;
  assign o_done     = r_done;
  assign o_busy     = r_busy;
endmodule

// File: tb/tb_grb_shipper.sv
// Directed bench for grb_shipper with NUM_LEDS=2, T0H=2, T1H=4, TBIT=6, TRESET=10.
// Honours GRB_SHIPPER_RGBW_EN for the 32-bit pixel variant.
module tb_grb_shipper;
  import ws2812_pkg::*;

  localparam int NL = 2, T0 = 2, T1 = 4, TB = 6, TR = 10, AW = 1;
  localparam int BPP = BITS_PER_PIXEL;
  localparam int PIX_CYC = 1 + BPP * TB;
`ifdef GRB_SHIPPER_RGBW_EN
  localparam int DONE_CYC = 396;
  localparam logic [31:0] PIX0 = 32'h8000_0001;
  localparam logic [31:0] PIX1 = 32'h00A5_00FF;
`else
  localparam int DONE_CYC = 300;
  localparam logic [23:0] PIX0 = 24'hA500FF;
  localparam logic [23:0] PIX1 = 24'h000001;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ship = 1'b0;
  logic [BPP-1:0] grb;
  logic [AW-1:0] addr;
  logic dout, done, busy;
  logic [BPP-1:0] pix [NL];

  int checks = 0;
  int errors = 0;

  logic          dq  [0:1023];
  logic          dnq [0:1023];
  logic          bq  [0:1023];
  logic [AW-1:0] aq  [0:1023];

  always #5 clk = ~clk;
  assign grb = pix[addr];

  grb_shipper #(.NUM_LEDS(NL), .T0H(T0), .T1H(T1), .TBIT(TB), .TRESET(TR), .ADDR_W(AW)) dut (
    .i_clk      (clk),
    .i_reset    (rst_n),
    .i_ship     (ship),
    .i_grb_data (grb),
    .o_led_addr (addr),
    .o_dout     (dout),
    .o_done     (done),
    .o_busy     (busy)
  );

  // Record n cycles at the falling edge; index 0 is the first FETCH when ship was set before the call
  task automatic capture(input int n, input int drop_at);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      dq[i] = dout; dnq[i] = done; bq[i] = busy; aq[i] = addr;
      if (i == drop_at) ship = 1'b0;
    end
  endtask

  // Ideal line level c cycles after the first FETCH
  function automatic logic exp_dout(input int c);
    int p, r, k, e;
    logic b;
    p = c / PIX_CYC;
    r = c % PIX_CYC;
    if (c < 0 || p >= NL || r == 0) return 1'b0;
    k = (r - 1) / TB;
    e = (r - 1) % TB;
    b = pix[p][BPP-1-k];
    return (e < (b ? T1 : T0));
  endfunction

  function automatic int wave_errs(input int off, input int n);
    int cnt;
    cnt = 0;
    for (int c = 0; c < n; c++) if (dq[off + c] !== exp_dout(c)) cnt++;
    return cnt;
  endfunction

  // Decode high-pulse widths of one pixel back into a word
  function automatic logic [BPP-1:0] decode(input int base);
    logic [BPP-1:0] w;
    int hi;
    w = '0;
    for (int k = 0; k < BPP; k++) begin
      hi = 0;
      for (int j = 0; j < TB; j++) if (dq[base + 1 + k * TB + j] === 1'b1) hi++;
      w[BPP-1-k] = (hi == T1) ? 1'b1 : (hi == T0) ? 1'b0 : 1'bx;
    end
    return w;
  endfunction

  function automatic int count_done(input int n);
    int cnt;
    cnt = 0;
    for (int i = 0; i < n; i++) if (dnq[i] === 1'b1) cnt++;
    return cnt;
  endfunction

  function automatic int next_done(input int from, input int n);
    for (int i = from; i < n; i++) if (dnq[i] === 1'b1) return i;
    return -1;
  endfunction

  task automatic test_reset();
    @(negedge clk);
    checks++; if (dout !== 1'b0) begin errors++; $display("FAIL rst_dout: got %b want 0", dout); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (addr !== 1'b0) begin errors++; $display("FAIL rst_addr: got %0d want 0", addr); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_single_frame();
    int e;
    @(negedge clk); ship = 1'b1;
    capture(DONE_CYC + 10, 0);
    checks++; if (decode(0) !== PIX0) begin errors++; $display("FAIL sf_pix0: got %0h want %0h", decode(0), PIX0); end
    checks++; if (decode(PIX_CYC) !== PIX1) begin errors++; $display("FAIL sf_pix1: got %0h want %0h", decode(PIX_CYC), PIX1); end
    e = wave_errs(0, DONE_CYC + 10);
    checks++; if (e !== 0) begin errors++; $display("FAIL sf_wave: got %0d bad cycles want 0", e); end
    checks++; if (dnq[DONE_CYC] !== 1'b1) begin errors++; $display("FAIL sf_done_cyc: got %b want 1", dnq[DONE_CYC]); end
    checks++; if (count_done(DONE_CYC + 10) !== 1) begin errors++; $display("FAIL sf_done_cnt: got %0d want 1", count_done(DONE_CYC + 10)); end
    checks++; if (aq[0] !== 1'b0) begin errors++; $display("FAIL sf_addr0: got %0d want 0", aq[0]); end
    checks++; if (aq[PIX_CYC] !== 1'b1) begin errors++; $display("FAIL sf_addr1: got %0d want 1", aq[PIX_CYC]); end
    checks++; if (bq[1] !== 1'b1) begin errors++; $display("FAIL sf_busy_run: got %b want 1", bq[1]); end
    checks++; if (bq[DONE_CYC + 1] !== 1'b0) begin errors++; $display("FAIL sf_busy_after: got %b want 0", bq[DONE_CYC + 1]); end
  endtask

  task automatic test_latch();
    int hi;
    @(negedge clk); ship = 1'b1;
    capture(DONE_CYC + 10, 0);
    hi = 0;
    for (int c = DONE_CYC - TR; c < DONE_CYC; c++) if (dq[c] !== 1'b0) hi++;
    checks++; if (hi !== 0) begin errors++; $display("FAIL latch_low: got %0d high cycles want 0", hi); end
    checks++; if (dnq[DONE_CYC - 1] !== 1'b0 || dnq[DONE_CYC + 1] !== 1'b0)
      begin errors++; $display("FAIL done_width: got %b%b want 00 around pulse", dnq[DONE_CYC - 1], dnq[DONE_CYC + 1]); end
    checks++; if (aq[DONE_CYC - 1] !== 1'b1) begin errors++; $display("FAIL latch_addr: got %0d want 1", aq[DONE_CYC - 1]); end
    checks++; if (bq[DONE_CYC] !== 1'b1) begin errors++; $display("FAIL done_busy: got %b want 1", bq[DONE_CYC]); end
  endtask

  task automatic test_back_to_back();
    int d1, d2, e;
    int f2;
    f2 = DONE_CYC + 2;
    @(negedge clk); ship = 1'b1;
    capture(f2 + DONE_CYC + 4, f2 + DONE_CYC + 1);
    d1 = next_done(0, f2 + DONE_CYC + 4);
    d2 = next_done(d1 + 1, f2 + DONE_CYC + 4);
    checks++; if (d1 !== DONE_CYC) begin errors++; $display("FAIL b2b_done1: got %0d want %0d", d1, DONE_CYC); end
    checks++; if (d2 - d1 !== DONE_CYC + 2) begin errors++; $display("FAIL b2b_gap: got %0d want %0d", d2 - d1, DONE_CYC + 2); end
    checks++; if (count_done(f2 + DONE_CYC + 4) !== 2) begin errors++; $display("FAIL b2b_cnt: got %0d want 2", count_done(f2 + DONE_CYC + 4)); end
    checks++; if (bq[DONE_CYC + 2] !== 1'b1 || aq[DONE_CYC + 2] !== 1'b0)
      begin errors++; $display("FAIL b2b_fetch2: got busy %b addr %0d want 1 0", bq[DONE_CYC + 2], aq[DONE_CYC + 2]); end
    e = 0;
    for (int c = 0; c < DONE_CYC; c++) if (dq[f2 + c] !== exp_dout(c)) e++;
    checks++; if (e !== 0) begin errors++; $display("FAIL b2b_wave2: got %0d bad cycles want 0", e); end
    checks++; if (bq[f2 + DONE_CYC + 3] !== 1'b0) begin errors++; $display("FAIL b2b_stop: got busy %b want 0", bq[f2 + DONE_CYC + 3]); end
  endtask

  task automatic test_ship_drop();
    int e;
    @(negedge clk); ship = 1'b1;
    capture(DONE_CYC + 10, 50);
    e = wave_errs(0, DONE_CYC + 10);
    checks++; if (e !== 0) begin errors++; $display("FAIL drop_wave: got %0d bad cycles want 0", e); end
    checks++; if (dnq[DONE_CYC] !== 1'b1) begin errors++; $display("FAIL drop_done: got %b want 1", dnq[DONE_CYC]); end
    checks++; if (count_done(DONE_CYC + 10) !== 1) begin errors++; $display("FAIL drop_cnt: got %0d want 1", count_done(DONE_CYC + 10)); end
  endtask

  task automatic test_mid_reset();
    int dn;
    @(negedge clk); ship = 1'b1;
    for (int i = 0; i <= 100; i++) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mr_busy_pre: got %b want 1", busy); end
`ifndef GRB_SHIPPER_RGBW_EN
    checks++; if (dout !== 1'b1) begin errors++; $display("FAIL mr_dout_pre: got %b want 1", dout); end
`endif
    #2 rst_n = 1'b0;
    #1;
    checks++; if (dout !== 1'b0) begin errors++; $display("FAIL mr_dout: got %b want 0", dout); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mr_busy: got %b want 0", busy); end
    checks++; if (addr !== 1'b0) begin errors++; $display("FAIL mr_addr: got %0d want 0", addr); end
    dn = 0;
    for (int i = 0; i < 3; i++) begin @(negedge clk); if (done !== 1'b0) dn++; end
    checks++; if (dn !== 0) begin errors++; $display("FAIL mr_done: got %0d pulses want 0", dn); end
    rst_n = 1'b1;
    capture(DONE_CYC + 10, 0);
    checks++; if (aq[0] !== 1'b0 || bq[0] !== 1'b1) begin errors++; $display("FAIL mr_restart: got addr %0d busy %b want 0 1", aq[0], bq[0]); end
    checks++; if (decode(0) !== PIX0) begin errors++; $display("FAIL mr_pix0: got %0h want %0h", decode(0), PIX0); end
    checks++; if (dnq[DONE_CYC] !== 1'b1) begin errors++; $display("FAIL mr_done_cyc: got %b want 1", dnq[DONE_CYC]); end
  endtask

  task automatic test_idle_quiet();
    int hd, hn, hb;
    hd = 0; hn = 0; hb = 0;
    ship = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (dout !== 1'b0) hd++;
      if (done !== 1'b0) hn++;
      if (busy !== 1'b0) hb++;
    end
    checks++; if (hd !== 0) begin errors++; $display("FAIL idle_dout: got %0d high cycles want 0", hd); end
    checks++; if (hn !== 0) begin errors++; $display("FAIL idle_done: got %0d high cycles want 0", hn); end
    checks++; if (hb !== 0) begin errors++; $display("FAIL idle_busy_q: got %0d high cycles want 0", hb); end
  endtask

  initial begin
    pix[0] = PIX0;
    pix[1] = PIX1;
    test_reset();
    test_single_frame();
    test_latch();
    test_back_to_back();
    test_ship_drop();
    test_mid_reset();
    test_idle_quiet();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
